// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle AND/XOR/SUB/ADD/CMP/OR with NZCV flags, plus an
// iterative shift-add MUL over WIDTH cycles when ALU_ITER_MUL_EN is defined.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             flags_only,
  output logic             busy
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
`ifdef ALU_ITER_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam int         CNT_W  = $clog2(WIDTH + 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd1
`ifdef ALU_ITER_MUL_EN
    , BUSY = 2'd2
`endif
  } state_t;

  state_t           state;
  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] eval_res;
  logic             eval_c;
  logic             eval_v;
  logic             eval_fo;

  function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] r, input logic c,
                                      input logic v);
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Single-cycle evaluation; unlisted opcodes (incl. MUL when disabled) give all ones
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    eval_res = '1;
    eval_c   = 1'b0;
    eval_v   = 1'b0;
    eval_fo  = 1'b0;
    case (op)
      OP_AND: eval_res = a & b;
      OP_XOR: eval_res = a ^ b;
      OP_OR:  eval_res = a | b;
      OP_ADD: begin
        eval_res = sum[WIDTH-1:0];
        eval_c   = sum[WIDTH];
        eval_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        eval_res = diff[WIDTH-1:0];
        eval_c   = ~diff[WIDTH];
        eval_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        eval_fo  = (op == OP_CMP);
      end
      default: ;
    endcase
  end

`ifdef ALU_ITER_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign busy     = (state == BUSY);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      result     <= '0;
      flags      <= '0;
      flags_only <= 1'b0;
`ifdef ALU_ITER_MUL_EN
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
`endif
    end else if (accept) begin
`ifdef ALU_ITER_MUL_EN
      if (op == OP_MUL) begin
        state  <= BUSY;
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= CNT_W'(WIDTH);
      end else
`endif
      begin
        state      <= DONE;
        result     <= eval_res;
        flags      <= nzcv(eval_res, eval_c, eval_v);
        flags_only <= eval_fo;
      end
    end
`ifdef ALU_ITER_MUL_EN
    // One shift-add step per cycle; the final step writes the low product bits
    else if (state == BUSY) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        state      <= DONE;
        result     <= acc_next;
        flags      <= nzcv(acc_next, 1'b0, 1'b0);
        flags_only <= 1'b0;
      end
    end
`endif
    else if ((state == DONE) && out_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter at WIDTH=32 and WIDTH=8; MUL checks follow ALU_ITER_MUL_EN.
module tb_alu_iter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, flags_only, busy;
  logic [31:0] a, b, result;
  logic [2:0]  op;
  logic [3:0]  flags;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, flags_only8, busy8;
  logic [7:0]  a8, b8, result8;
  logic [2:0]  op8;
  logic [3:0]  flags8;

  int tests = 0;
  int fails = 0;
  int lat, nbusy;

  alu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .flags_only(flags_only), .busy(busy)
  );

  alu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .flags(flags8), .flags_only(flags_only8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
  endtask

  task automatic drive8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    in_valid8 = 1'b1;
    op8       = o;
    a8        = x;
    b8        = y;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = 3'd0; a8 = '0; b8 = '0;
    step(); step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_flags_only", flags_only, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Single-cycle ops, back-to-back with out_ready held high
    drive32(3'b011, 32'h7FFF_FFFF, 32'h1); step();
    check("add_ovf_valid", out_valid, 1);
    check("add_ovf_result", result, 32'h8000_0000);
    check("add_ovf_flags", flags, 4'b1001);
    check("add_ovf_fo", flags_only, 0);
    drive32(3'b010, 32'd5, 32'd7); step();
    check("sub_valid", out_valid, 1);
    check("sub_result", result, 32'hFFFF_FFFE);
    check("sub_flags", flags, 4'b1000);
    drive32(3'b100, 32'd9, 32'd9); step();
    check("cmp_result", result, 0);
    check("cmp_flags", flags, 4'b0110);
    check("cmp_fo", flags_only, 1);
    drive32(3'b011, 32'hFFFF_FFFF, 32'h1); step();
    check("add_carry_result", result, 0);
    check("add_carry_flags", flags, 4'b0110);
    check("add_carry_fo", flags_only, 0);
    drive32(3'b010, 32'h8000_0000, 32'h1); step();
    check("sub_ovf_result", result, 32'h7FFF_FFFF);
    check("sub_ovf_flags", flags, 4'b0011);
    drive32(3'b001, 32'hA5A5_A5A5, 32'hFFFF_FFFF); step();
    check("xor_result", result, 32'h5A5A_5A5A);
    check("xor_flags", flags, 4'b0000);
    drive32(3'b111, 32'h1, 32'h2); step();
    check("inv_result", result, 32'hFFFF_FFFF);
    check("inv_flags", flags, 4'b1000);
    in_valid = 1'b0; step();
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);

    // Consumer stall: result held, competing request not accepted
    out_ready = 1'b0;
    drive32(3'b000, 32'hF0F0_F0F0, 32'h0F0F_0F0F); step();
    drive32(3'b101, 32'h1, 32'h2);
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_result", result, 0);
      check("hold_flags", flags, 4'b0100);
      check("hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1; #1;
    check("release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("or_valid", out_valid, 1);
    check("or_result", result, 32'd3);
    check("or_flags", flags, 4'b0000);
    step();
    check("or_drain", out_valid, 0);

`ifdef ALU_ITER_MUL_EN
    drive32(3'b110, 32'h0001_0003, 32'h0000_0005); step();
    in_valid = 1'b0;
    check("mul_in_ready_busy", in_ready, 0);
    lat = 0; nbusy = 0;
    while (!out_valid && lat < 40) begin
      if (busy) nbusy++;
      step();
      lat++;
    end
    check("mul_latency", lat, 32);
    check("mul_busy_cycles", nbusy, 32);
    check("mul_result", result, 32'h0005_000F);
    check("mul_flags", flags, 4'b0000);
    check("mul_busy_done", busy, 0);
    // Back-to-back MUL drops out_valid, then reset on its 10th BUSY cycle
    drive32(3'b110, 32'h0000_1234, 32'h0000_0010); step();
    in_valid = 1'b0;
    check("mul2_out_valid", out_valid, 0);
    check("mul2_busy", busy, 1);
    repeat (9) step();
    check("mul2_busy10", busy, 1);
    rst_n = 1'b0; step();
    check("mrst_out_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_result", result, 0);
    check("mrst_flags", flags, 0);
    rst_n = 1'b1;
`else
    drive32(3'b110, 32'h3, 32'h5); step();
    in_valid = 1'b0;
    check("mul_off_valid", out_valid, 1);
    check("mul_off_result", result, 32'hFFFF_FFFF);
    check("mul_off_flags", flags, 4'b1000);
    check("mul_off_busy", busy, 0);
    step();
    out_ready = 1'b0;
    drive32(3'b011, 32'd6, 32'd7); step();
    in_valid = 1'b0;
    check("pre_rst_result", result, 32'd13);
    rst_n = 1'b0; step();
    check("drst_out_valid", out_valid, 0);
    check("drst_in_ready", in_ready, 1);
    check("drst_result", result, 0);
    check("drst_flags", flags, 0);
    rst_n = 1'b1; out_ready = 1'b1;
`endif
    drive32(3'b011, 32'd2, 32'd3); step();
    in_valid = 1'b0;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_result", result, 32'd5);
    check("post_rst_flags", flags, 4'b0000);
    step();

    // WIDTH=8 instance
    drive8(3'b111, 8'd3, 8'd4); step();
    check("w8_inv_valid", out_valid8, 1);
    check("w8_inv_result", result8, 8'hFF);
    check("w8_inv_flags", flags8, 4'b1000);
    drive8(3'b011, 8'h7F, 8'h01); step();
    check("w8_add_result", result8, 8'h80);
    check("w8_add_flags", flags8, 4'b1001);
`ifdef ALU_ITER_MUL_EN
    drive8(3'b110, 8'h10, 8'h0F); step();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      step();
      lat++;
    end
    check("w8_mul_latency", lat, 8);
    check("w8_mul_result", result8, 8'hF0);
    check("w8_mul_flags", flags8, 4'b1000);
`else
    drive8(3'b110, 8'h10, 8'h0F); step();
    in_valid8 = 1'b0;
    check("w8_mul_off_valid", out_valid8, 1);
    check("w8_mul_off_result", result8, 8'hFF);
    check("w8_mul_off_flags", flags8, 4'b1000);
    check("w8_mul_off_busy", busy8, 0);
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
